// File: rtl/bcd_7seg_scan_driver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_7seg_scan_driver_if : load/data inputs and display outputs    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface bcd_7seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_en;
  logic [6:0]              segment;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    err;

  modport master (
    output load, bcd_in, dp_in, blank_en,
    input  segment, dp, digit_en, err
  );

  modport slave (
    input  load, bcd_in, dp_in, blank_en,
    output segment, dp, digit_en, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_7seg_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_7seg_scan_driver : multiplexed multi-digit BCD to 7-seg scan  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter bit COMMON_ANODE  = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  bcd_7seg_scan_driver_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic INACTIVE = COMMON_ANODE;

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        index;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    higher_zero;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    any_invalid;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_lead;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   en_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Walk from the most significant digit down; a digit is leading-zero only
  // while every digit above it is also zero. Digit 0 is never blanked.
  always_comb begin
    higher_zero = 1'b1;
    lead_zero   = '0;
    any_invalid = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero  = higher_zero && (shadow_bcd[4*i +: 4] == 4'd0);
      lead_zero[i] = BLANK_LEADING && (i != 0) && higher_zero;
      any_invalid  = any_invalid || (shadow_bcd[4*i +: 4] > 4'd9);
    end
  end

  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_lead = 1'b0;
    en_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        cur_code   = shadow_bcd[4*i +: 4];
        cur_dp     = shadow_dp[i];
        cur_lead   = lead_zero[i];
        en_next[i] = (prescaler != PRE_LAST) && !bus.blank_en;
      end
    end
    seg_next = cur_lead ? 7'h00 : decode(cur_code);
    dp_next  = cur_lead ? 1'b0 : cur_dp;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler    <= '0;
      index        <= '0;
      shadow_bcd   <= '0;
      shadow_dp    <= '0;
      bus.segment  <= {7{INACTIVE}};
      bus.dp       <= INACTIVE;
      bus.digit_en <= {NUM_DIGITS{INACTIVE}};
      bus.err      <= 1'b0;
    end else begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        index     <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      if (bus.load) begin
        shadow_bcd <= bus.bcd_in;
        shadow_dp  <= bus.dp_in;
      end
      bus.segment  <= seg_next ^ {7{INACTIVE}};
      bus.dp       <= dp_next ^ INACTIVE;
      bus.digit_en <= en_next ^ {NUM_DIGITS{INACTIVE}};
      bus.err      <= any_invalid;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench: two driver configurations share one stimulus stream and
// are compared every clock against an arithmetic display model.
module tb_bcd_7seg_scan_driver;
  localparam int NA = 4, DIVA = 4;
  localparam bit CAA = 1'b0, BLA = 1'b1;
  localparam int NB = 3, DIVB = 3;
  localparam bit CAB = 1'b1, BLB = 1'b0;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] en;
    logic       err;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] word  = '0;
  logic [3:0]  dpw   = '0;
  logic        blank = 1'b0;

  int checks = 0;
  int errors = 0;
  obs_t qa[$];
  obs_t qb[$];

  always #5 clock = ~clock;

  bcd_7seg_scan_driver_if #(.NUM_DIGITS(NA)) ifa ();
  bcd_7seg_scan_driver_if #(.NUM_DIGITS(NB)) ifb ();

  assign ifa.load     = load;
  assign ifa.bcd_in   = word;
  assign ifa.dp_in    = dpw;
  assign ifa.blank_en = blank;
  assign ifb.load     = load;
  assign ifb.bcd_in   = word[11:0];
  assign ifb.dp_in    = dpw[2:0];
  assign ifb.blank_en = blank;

  bcd_7seg_scan_driver #(.NUM_DIGITS(NA), .REFRESH_DIV(DIVA), .COMMON_ANODE(CAA), .BLANK_LEADING(BLA))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));
  bcd_7seg_scan_driver #(.NUM_DIGITS(NB), .REFRESH_DIV(DIVB), .COMMON_ANODE(CAB), .BLANK_LEADING(BLB))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  function automatic logic [6:0] seg_of(input int code);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (code > 9) ? 7'h40 : tab[code];
  endfunction

  // c = number of clock edges since reset release before the edge being predicted
  function automatic obs_t predict(input int n, input int div, input bit ca, input bit bl,
                                   input int c, input logic [31:0] w, input logic [7:0] d,
                                   input bit blk);
    obs_t o;
    int pre, idx;
    logic [31:0] upper;
    pre   = c % div;
    idx   = (c / div) % n;
    upper = w >> (4 * idx);
    o.err = 1'b0;
    for (int i = 0; i < n; i++)
      if (((w >> (4 * i)) & 32'hF) > 32'd9) o.err = 1'b1;
    if (bl && idx > 0 && upper == 32'd0) begin
      o.seg = 7'h00;
      o.dp  = 1'b0;
    end else begin
      o.seg = seg_of(int'(upper & 32'hF));
      o.dp  = d[idx];
    end
    o.en = (pre == div - 1 || blk) ? 8'h00 : 8'(1 << idx);
    if (ca) begin
      o.seg = ~o.seg;
      o.dp  = ~o.dp;
      o.en  = ~o.en & 8'((1 << n) - 1);
    end
    return o;
  endfunction

  function automatic obs_t idle(input bit ca, input int n);
    obs_t o;
    o.seg = ca ? 7'h7F : 7'h00;
    o.dp  = ca;
    o.en  = ca ? 8'((1 << n) - 1) : 8'h00;
    o.err = 1'b0;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got seg=%h dp=%b en=%b err=%b, want seg=%h dp=%b en=%b err=%b",
               name, $time, act.seg, act.dp, act.en, act.err, exp.seg, exp.dp, exp.en, exp.err);
    end
  endtask

  function automatic obs_t obs_a();
    return '{seg: ifa.segment, dp: ifa.dp, en: 8'(ifa.digit_en), err: ifa.err};
  endfunction

  function automatic obs_t obs_b();
    return '{seg: ifb.segment, dp: ifb.dp, en: 8'(ifb.digit_en), err: ifb.err};
  endfunction

  // Reference model: pushes one expectation per DUT per clock edge
  int c = 0;
  logic [15:0] sh_w = '0;
  logic [3:0]  sh_d = '0;
  initial forever begin
    @(posedge clock);
    if (!reset) begin
      qa.push_back(idle(CAA, NA));
      qb.push_back(idle(CAB, NB));
      c = 0; sh_w = '0; sh_d = '0;
    end else begin
      qa.push_back(predict(NA, DIVA, CAA, BLA, c, {16'h0, sh_w}, {4'h0, sh_d}, blank));
      qb.push_back(predict(NB, DIVB, CAB, BLB, c, {20'h0, sh_w[11:0]}, {5'h0, sh_d[2:0]}, blank));
      c++;
      if (load) begin
        sh_w = word;
        sh_d = dpw;
      end
    end
  end

  // Monitor: pops and compares after every edge
  initial forever begin
    @(posedge clock);
    #1;
    if (qa.size() == 0) begin
      checks++; errors++;
      $display("FAIL dut_a: no expectation queued at %0t", $time);
    end else compare("dut_a", obs_a(), qa.pop_front());
    if (qb.size() == 0) begin
      checks++; errors++;
      $display("FAIL dut_b: no expectation queued at %0t", $time);
    end else compare("dut_b", obs_b(), qb.pop_front());
  end

  task automatic do_load(input logic [15:0] w, input logic [3:0] d);
    @(negedge clock);
    word = w; dpw = d; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    compare({tag, "_a"}, obs_a(), idle(CAA, NA));
    compare({tag, "_b"}, obs_b(), idle(CAB, NB));
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    #1 reset = 1'b0;
    #1;
    compare("por_a", obs_a(), idle(CAA, NA));
    compare("por_b", obs_b(), idle(CAB, NB));
    run(2);
    reset = 1'b1;

    do_load(16'h1234, 4'b0000); run(36);
    do_load(16'h0070, 4'b0000); run(20);
    do_load(16'h0000, 4'b0000); run(20);
    do_load(16'h00A5, 4'b0000); run(20);
    do_load(16'h0005, 4'b0000); run(10);
    do_load(16'h1234, 4'b0100); run(20);
    blank = 1'b1; run(11);
    blank = 1'b0; run(20);
    run(7);
    async_reset("midslot_rst");
    run(20);
    do_load(16'h8888, 4'b1111); run(20);

    repeat (40) begin
      for (int i = 0; i < 4; i++)
        w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
      do_load(w, 4'($urandom_range(0, 15)));
      blank = ($urandom_range(0, 5) == 0);
      run($urandom_range(4, 24));
      blank = 1'b0;
      if ($urandom_range(0, 12) == 0) async_reset("rand_rst");
    end

    @(posedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
